// File: rtl/sipo_collector.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_collector
//  Purpose  : Serial-in parallel-out word collector with a 1-deep valid/ready
//             holding register and a sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module sipo_collector #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     sin,
    input  logic                     sin_valid,
    input  logic                     sync,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     overrun
);

    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   sr_shift;
    logic               shift_en;
    logic               word_done;
    logic               load;
    logic               drop;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign sr_shift = {sin, sr[WIDTH-1:1]};
        end else begin : g_msb_first
            assign sr_shift = {sr[WIDTH-2:0], sin};
        end
    endgenerate

    // sync suppresses any strobe in the same cycle.
    assign shift_en   = sin_valid & ~sync;
    assign word_done  = shift_en & (bit_cnt == LAST);
    assign dout_valid = (state == FULL);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (word_done) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (word_done) begin
                    // Consumer taking the old word frees the slot for the new one.
                    if (dout_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (dout_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            if (sync) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else if (sin_valid) begin
                sr      <= sr_shift;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (load) begin
                dout <= sr_shift;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_collector
//  Purpose  : Scoreboard bench for sipo_collector, LSB-first and MSB-first
//             instances driven by the same serial stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sipo_collector;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sync = 1'b0;
    logic       dout_ready = 1'b0;
    logic [3:0] dout_a, dout_b;
    logic       dv_a, dv_b, ov_a, ov_b;
    logic [2:0] bc_a, bc_b;

    sipo_collector #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .dout(dout_a), .dout_valid(dv_a), .dout_ready(dout_ready),
        .bit_cnt(bc_a), .overrun(ov_a)
    );

    sipo_collector #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .dout(dout_b), .dout_valid(dv_b), .dout_ready(dout_ready),
        .bit_cnt(bc_b), .overrun(ov_b)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    bit         check_en = 1'b0;

    // Reference model: bits received so far, holding slot, expected words.
    bit         bits[$];
    bit         m_valid = 1'b0;
    bit         m_over = 1'b0;
    logic [3:0] m_wa = '0;
    logic [3:0] m_wb = '0;
    logic [7:0] expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit         done;
        logic [3:0] wa, wb;
        done = 1'b0;
        wa = '0;
        wb = '0;
        if (clr) begin
            bits.delete();
            expq.delete();
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_wa    = '0;
            m_wb    = '0;
        end else begin
            if (sync) begin
                bits.delete();
            end else if (sin_valid) begin
                bits.push_back(sin);
                if (bits.size() == 4) begin
                    done = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        wa[k]     = bits[k];
                        wb[3 - k] = bits[k];
                    end
                    bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || dout_ready) begin
                    m_valid = 1'b1;
                    m_wa    = wa;
                    m_wb    = wb;
                    expq.push_back({wa, wb});
                end else begin
                    m_over = 1'b1;
                end
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic s, input logic v, input logic sy,
                        input logic rd, input logic c);
        sin        = s;
        sin_valid  = v;
        sync       = sy;
        dout_ready = rd;
        clr        = c;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send_bits(input logic [3:0] b, input logic rd);
        for (int i = 0; i < 4; i++) begin
            step(b[3 - i], 1'b1, 1'b0, rd, 1'b0);
        end
    endtask

    // Monitor: per-cycle state against the model, and scoreboard pop on handshake.
    always @(negedge clk) begin
        if (check_en) begin
            logic [7:0] e;
            chk("bit_cnt_a", {29'd0, bc_a}, bits.size());
            chk("bit_cnt_b", {29'd0, bc_b}, bits.size());
            chk("dout_valid_a", {31'd0, dv_a}, {31'd0, m_valid});
            chk("dout_valid_b", {31'd0, dv_b}, {31'd0, m_valid});
            chk("overrun_a", {31'd0, ov_a}, {31'd0, m_over});
            chk("overrun_b", {31'd0, ov_b}, {31'd0, m_over});
            if (dv_a && dout_ready) begin
                if (expq.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("sb_dout_a", {28'd0, dout_a}, {28'd0, e[7:4]});
                    chk("sb_dout_b", {28'd0, dout_b}, {28'd0, e[3:0]});
                end
            end
        end
    end

    initial begin
        // Reset with random serial activity underneath.
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
        end
        chk("reset_dout", {24'd0, dout_a, dout_b}, 32'd0);
        chk("reset_valid", {30'd0, dv_a, dv_b}, 32'd0);
        chk("reset_overrun", {30'd0, ov_a, ov_b}, 32'd0);
        chk("reset_bit_cnt", {26'd0, bc_a, bc_b}, 32'd0);
        check_en = 1'b1;

        // Round trip: arrival 0,1,0,1.
        send_bits(4'b0101, 1'b1);
        chk("rt_dout_a", {28'd0, dout_a}, 32'hA);
        chk("rt_dout_b", {28'd0, dout_b}, 32'h5);
        chk("rt_valid", {31'd0, dv_a}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rt_valid_drop", {31'd0, dv_a}, 32'd0);

        // Gapped bits 1,1,0,0 with 3 idle cycles between strobes.
        for (int i = 0; i < 4; i++) begin
            step((i < 2), 1'b1, 1'b0, 1'b0, 1'b0);
            for (int g = 0; g < 3 && i < 3; g++) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("gap_bit_cnt", {29'd0, bc_b}, i + 1);
            end
        end
        chk("gap_dout_b", {28'd0, dout_b}, 32'hC);
        chk("gap_dout_a", {28'd0, dout_a}, 32'h3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: two words with the consumer stalled.
        send_bits(4'b0101, 1'b0);
        send_bits(4'b0110, 1'b0);
        chk("ovr_dout_kept", {28'd0, dout_a}, 32'hA);
        chk("ovr_flag", {31'd0, ov_a}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_valid_drop", {31'd0, dv_a}, 32'd0);
        chk("ovr_sticky", {31'd0, ov_a}, 32'd1);

        // Back-to-back handoff with no bubble.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(4'b0101, 1'b0);
        chk("b2b_first", {28'd0, dout_a}, 32'hA);
        for (int i = 0; i < 4; i++) begin
            step(1'(i % 2 == 0), 1'b1, 1'b0, (i == 3), 1'b0);
            chk("b2b_valid_held", {31'd0, dv_a}, 32'd1);
        end
        chk("b2b_second", {28'd0, dout_a}, 32'h5);
        chk("b2b_no_overrun", {31'd0, ov_a}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Realign after 2 bits, strobe during sync is ignored.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sync_bit_cnt", {29'd0, bc_a}, 32'd0);
        send_bits(4'b0011, 1'b1);
        chk("sync_dout", {28'd0, dout_a}, 32'hC);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // clr mid-word.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_mid_bit_cnt", {29'd0, bc_a}, 32'd0);
        chk("clr_mid_valid", {31'd0, dv_a}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 299) == 0));
        end

        chk("final_scoreboard_depth", expq.size(), {31'd0, m_valid});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
